// File: rtl/z16_pkg.sv
// Shared widths and ALU control codes for the Z16 operand/issue stage.
package z16_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_NUM = 16;
  localparam int ADDR_W  = 4;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_MUL = 4'd2,
    ALU_DIV = 4'd3,
    ALU_OR  = 4'd4,
    ALU_AND = 4'd5,
    ALU_XOR = 4'd6,
    ALU_SHL = 4'd7,
    ALU_SHR = 4'd8
  } alu_ctrl_e;

endpackage

// File: rtl/z16_operand_stage_if.sv
// Bundle of issue, ALU-facing and write-back signals around the operand stage.
interface z16_operand_stage_if;
  import z16_pkg::*;

  logic        i_valid;
  logic        o_ready;
  logic [3:0]  i_ctrl;
  addr_t       i_rs_a;
  addr_t       i_rs_b;
  logic        i_use_imm;
  data_t       i_imm;
  addr_t       i_rd;
  logic        i_rd_we;

  logic        o_valid;
  logic        i_ready;
  data_t       o_data_a;
  data_t       o_data_b;
  logic [3:0]  o_ctrl;
  addr_t       o_rd;
  logic        o_rd_we;

  logic        i_wb_en;
  addr_t       i_wb_addr;
  data_t       i_wb_data;

  // Decoder/ALU/write-back side of the stage
  modport master (
    output i_valid, i_ctrl, i_rs_a, i_rs_b, i_use_imm, i_imm, i_rd, i_rd_we,
    output i_ready, i_wb_en, i_wb_addr, i_wb_data,
    input  o_ready, o_valid, o_data_a, o_data_b, o_ctrl, o_rd, o_rd_we
  );

  modport slave (
    input  i_valid, i_ctrl, i_rs_a, i_rs_b, i_use_imm, i_imm, i_rd, i_rd_we,
    input  i_ready, i_wb_en, i_wb_addr, i_wb_data,
    output o_ready, o_valid, o_data_a, o_data_b, o_ctrl, o_rd, o_rd_we
  );

endinterface

// File: rtl/z16_scoreboard.sv
// Per-register pending-write bits with busy lookups that look through a same-cycle write-back.
module z16_scoreboard
  import z16_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_set_en,
  input  addr_t i_set_addr,
  input  logic  i_clr_en,
  input  addr_t i_clr_addr,
  input  addr_t i_rs_a,
  input  addr_t i_rs_b,
  input  addr_t i_rd,
  output logic  o_busy_a,
  output logic  o_busy_b,
  output logic  o_busy_rd
);

  logic [REG_NUM-1:0] pend_q;
  logic [REG_NUM-1:0] pend_d;
  logic [REG_NUM-1:0] clr_mask;
  logic [REG_NUM-1:0] set_mask;

  // A new issue to the same register overrides the returning write-back.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (i_clr_en) clr_mask[i_clr_addr] = 1'b1;
    if (i_set_en) set_mask[i_set_addr] = 1'b1;
    pend_d    = (pend_q & ~clr_mask) | set_mask;
    o_busy_a  = pend_q[i_rs_a] & ~clr_mask[i_rs_a];
    o_busy_b  = pend_q[i_rs_b] & ~clr_mask[i_rs_b];
    o_busy_rd = pend_q[i_rd]   & ~clr_mask[i_rd];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) pend_q <= '0;
    else       pend_q <= pend_d;
  end

endmodule

// File: rtl/z16_operand_stage.sv
// Operand fetch/issue stage: register file, hazard stall and one-entry output register to the ALU.
module z16_operand_stage
  import z16_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  z16_operand_stage_if.slave  bus
);

  data_t      regs_q [REG_NUM];
  data_t      regs_d [REG_NUM];

  logic       valid_q, valid_d;
  data_t      data_a_q, data_a_d;
  data_t      data_b_q, data_b_d;
  logic [3:0] ctrl_q, ctrl_d;
  addr_t      rd_q, rd_d;
  logic       rd_we_q, rd_we_d;

  logic       busy_a, busy_b, busy_rd;
  logic       hazard, ready, accept;
  logic       wb_hit_a, wb_hit_b;

  z16_scoreboard u_scoreboard (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_set_en   (accept & bus.i_rd_we),
    .i_set_addr (bus.i_rd),
    .i_clr_en   (bus.i_wb_en),
    .i_clr_addr (bus.i_wb_addr),
    .i_rs_a     (bus.i_rs_a),
    .i_rs_b     (bus.i_rs_b),
    .i_rd       (bus.i_rd),
    .o_busy_a   (busy_a),
    .o_busy_b   (busy_b),
    .o_busy_rd  (busy_rd)
  );

  // Ready ignores i_valid so the decoder can hold an instruction against it.
  always_comb begin
    wb_hit_a = bus.i_wb_en && (bus.i_wb_addr == bus.i_rs_a);
    wb_hit_b = bus.i_wb_en && (bus.i_wb_addr == bus.i_rs_b);
    hazard   = busy_a | (~bus.i_use_imm & busy_b) | (bus.i_rd_we & busy_rd);
    ready    = (~valid_q | bus.i_ready) & ~hazard;
    accept   = bus.i_valid & ready;

    regs_d = regs_q;
    if (bus.i_wb_en) regs_d[bus.i_wb_addr] = bus.i_wb_data;

    valid_d  = valid_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    ctrl_d   = ctrl_q;
    rd_d     = rd_q;
    rd_we_d  = rd_we_q;
    if (accept) begin
      valid_d  = 1'b1;
      data_a_d = wb_hit_a ? bus.i_wb_data : regs_q[bus.i_rs_a];
      data_b_d = bus.i_use_imm ? bus.i_imm
               : (wb_hit_b ? bus.i_wb_data : regs_q[bus.i_rs_b]);
      ctrl_d   = bus.i_ctrl;
      rd_d     = bus.i_rd;
      rd_we_d  = bus.i_rd_we;
    end else if (bus.i_ready) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      valid_q  <= 1'b0;
      data_a_q <= '0;
      data_b_q <= '0;
      ctrl_q   <= '0;
      rd_q     <= '0;
      rd_we_q  <= 1'b0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= regs_d[i];
      valid_q  <= valid_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      ctrl_q   <= ctrl_d;
      rd_q     <= rd_d;
      rd_we_q  <= rd_we_d;
    end
  end

  always_comb begin
    bus.o_ready  = ready;
    bus.o_valid  = valid_q;
    bus.o_data_a = data_a_q;
    bus.o_data_b = data_b_q;
    bus.o_ctrl   = ctrl_q;
    bus.o_rd     = rd_q;
    bus.o_rd_we  = rd_we_q;
  end

endmodule

// File: tb/tb_z16_operand_stage.sv
// Directed bench for the Z16 operand stage: bypass, hazard stall, back-pressure, immediates, reset.
module tb_z16_operand_stage;
  import z16_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  z16_operand_stage_if bus ();

  z16_operand_stage dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.i_valid   = 1'b0;
    bus.i_ctrl    = 4'd0;
    bus.i_rs_a    = '0;
    bus.i_rs_b    = '0;
    bus.i_use_imm = 1'b0;
    bus.i_imm     = '0;
    bus.i_rd      = '0;
    bus.i_rd_we   = 1'b0;
  endtask

  task automatic drive_issue(input logic [3:0] ctrl, input addr_t rs_a, input addr_t rs_b,
                             input logic use_imm, input data_t imm, input addr_t rd, input logic rd_we);
    bus.i_valid   = 1'b1;
    bus.i_ctrl    = ctrl;
    bus.i_rs_a    = rs_a;
    bus.i_rs_b    = rs_b;
    bus.i_use_imm = use_imm;
    bus.i_imm     = imm;
    bus.i_rd      = rd;
    bus.i_rd_we   = rd_we;
  endtask

  task automatic drive_wb(input logic en, input addr_t addr, input data_t data);
    bus.i_wb_en   = en;
    bus.i_wb_addr = addr;
    bus.i_wb_data = data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %0b expected 0", bus.o_valid); end
    n_checks++; if (bus.o_data_a !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_data_a: got %h expected 0000", bus.o_data_a); end
    n_checks++; if (bus.o_data_b !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_data_b: got %h expected 0000", bus.o_data_b); end
    n_checks++; if (bus.o_ctrl !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_ctrl: got %0d expected 0", bus.o_ctrl); end
    n_checks++; if (bus.o_rd !== 4'd0 || bus.o_rd_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd: got rd=%0d we=%0b expected 0/0", bus.o_rd, bus.o_rd_we); end
    @(negedge clk);
    n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %0b expected 1", bus.o_ready); end
    step();
  endtask

  task automatic test_basic();
    drive_wb(1'b1, 4'd1, 16'd5);
    step();
    drive_wb(1'b1, 4'd2, 16'd7);
    step();
    drive_wb(1'b0, 4'd0, 16'd0);
    drive_issue(ALU_ADD, 4'd1, 4'd2, 1'b0, 16'h0, 4'd6, 1'b0);
    @(negedge clk);
    n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_ready: got %0b expected 1", bus.o_ready); end
    step();
    drive_idle();
    n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_valid: got %0b expected 1", bus.o_valid); end
    n_checks++; if (bus.o_data_a !== 16'd5) begin n_fail++; $display("[TB] FAIL basic_data_a: got %h expected 0005", bus.o_data_a); end
    n_checks++; if (bus.o_data_b !== 16'd7) begin n_fail++; $display("[TB] FAIL basic_data_b: got %h expected 0007", bus.o_data_b); end
    n_checks++; if (bus.o_ctrl !== 4'd0 || bus.o_rd !== 4'd6 || bus.o_rd_we !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_ctrl_rd: got ctrl=%0d rd=%0d we=%0b expected 0/6/0", bus.o_ctrl, bus.o_rd, bus.o_rd_we); end
    step();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_drain: got %0b expected 0", bus.o_valid); end
  endtask

  task automatic test_raw();
    drive_issue(ALU_SUB, 4'd1, 4'd2, 1'b0, 16'h0, 4'd3, 1'b1);
    step();
    n_checks++; if (bus.o_valid !== 1'b1 || bus.o_rd !== 4'd3 || bus.o_rd_we !== 1'b1 || bus.o_ctrl !== 4'd1) begin n_fail++; $display("[TB] FAIL raw_producer: got v=%0b rd=%0d we=%0b ctrl=%0d expected 1/3/1/1", bus.o_valid, bus.o_rd, bus.o_rd_we, bus.o_ctrl); end
    drive_issue(ALU_AND, 4'd3, 4'd1, 1'b0, 16'h0, 4'd8, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL raw_stall%0d: got %0b expected 0", i, bus.o_ready); end
      step();
    end
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL raw_bubble: got %0b expected 0", bus.o_valid); end
    drive_wb(1'b1, 4'd3, 16'h0010);
    @(negedge clk);
    n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL raw_wb_ready: got %0b expected 1", bus.o_ready); end
    step();
    drive_idle();
    drive_wb(1'b0, 4'd0, 16'd0);
    n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL raw_valid: got %0b expected 1", bus.o_valid); end
    n_checks++; if (bus.o_data_a !== 16'h0010) begin n_fail++; $display("[TB] FAIL raw_bypass_a: got %h expected 0010", bus.o_data_a); end
    n_checks++; if (bus.o_data_b !== 16'd5 || bus.o_ctrl !== 4'd5) begin n_fail++; $display("[TB] FAIL raw_b_ctrl: got b=%h ctrl=%0d expected 0005/5", bus.o_data_b, bus.o_ctrl); end
  endtask

  task automatic test_backpressure();
    bus.i_ready = 1'b0;
    drive_issue(ALU_XOR, 4'd2, 4'd1, 1'b0, 16'h0, 4'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ready%0d: got %0b expected 0", i, bus.o_ready); end
      step();
      n_checks++; if (bus.o_valid !== 1'b1 || bus.o_data_a !== 16'h0010 || bus.o_data_b !== 16'd5 || bus.o_ctrl !== 4'd5 || bus.o_rd !== 4'd8)
        begin n_fail++; $display("[TB] FAIL bp_hold%0d: got v=%0b a=%h b=%h ctrl=%0d rd=%0d expected 1/0010/0005/5/8", i, bus.o_valid, bus.o_data_a, bus.o_data_b, bus.o_ctrl, bus.o_rd); end
    end
    bus.i_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_release_ready: got %0b expected 1", bus.o_ready); end
    step();
    drive_idle();
    n_checks++; if (bus.o_valid !== 1'b1 || bus.o_data_a !== 16'd7 || bus.o_data_b !== 16'd5 || bus.o_ctrl !== 4'd6 || bus.o_rd !== 4'd7)
      begin n_fail++; $display("[TB] FAIL bp_next: got v=%0b a=%h b=%h ctrl=%0d rd=%0d expected 1/0007/0005/6/7", bus.o_valid, bus.o_data_a, bus.o_data_b, bus.o_ctrl, bus.o_rd); end
    step();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_drain: got %0b expected 0", bus.o_valid); end
  endtask

  task automatic test_imm();
    drive_issue(ALU_ADD, 4'd1, 4'd2, 1'b0, 16'h0, 4'd4, 1'b1);
    step();
    drive_issue(ALU_OR, 4'd1, 4'd4, 1'b1, 16'hBEEF, 4'd9, 1'b0);
    @(negedge clk);
    n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL imm_ready: got %0b expected 1", bus.o_ready); end
    step();
    n_checks++; if (bus.o_data_a !== 16'd5 || bus.o_data_b !== 16'hBEEF || bus.o_ctrl !== 4'd4)
      begin n_fail++; $display("[TB] FAIL imm_operands: got a=%h b=%h ctrl=%0d expected 0005/beef/4", bus.o_data_a, bus.o_data_b, bus.o_ctrl); end
    drive_issue(ALU_OR, 4'd1, 4'd4, 1'b0, 16'h0, 4'd9, 1'b0);
    @(negedge clk);
    n_checks++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL imm_reg_b_stall: got %0b expected 0", bus.o_ready); end
    drive_idle();
    drive_wb(1'b1, 4'd4, 16'h1234);
    step();
    drive_wb(1'b0, 4'd0, 16'd0);
  endtask

  task automatic test_set_wins();
    drive_issue(ALU_ADD, 4'd1, 4'd2, 1'b0, 16'h0, 4'd5, 1'b1);
    step();
    drive_issue(ALU_MUL, 4'd1, 4'd2, 1'b0, 16'h0, 4'd5, 1'b1);
    drive_wb(1'b1, 4'd5, 16'h0055);
    @(negedge clk);
    n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL setwin_accept: got %0b expected 1", bus.o_ready); end
    step();
    drive_wb(1'b0, 4'd0, 16'd0);
    drive_issue(ALU_SHL, 4'd5, 4'd1, 1'b0, 16'h0, 4'd10, 1'b0);
    @(negedge clk);
    n_checks++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL setwin_stall: got %0b expected 0", bus.o_ready); end
    step();
    drive_wb(1'b1, 4'd5, 16'h0066);
    @(negedge clk);
    n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL setwin_release: got %0b expected 1", bus.o_ready); end
    step();
    drive_idle();
    drive_wb(1'b0, 4'd0, 16'd0);
    n_checks++; if (bus.o_valid !== 1'b1 || bus.o_data_a !== 16'h0066 || bus.o_data_b !== 16'd5 || bus.o_ctrl !== 4'd7)
      begin n_fail++; $display("[TB] FAIL setwin_operands: got v=%0b a=%h b=%h ctrl=%0d expected 1/0066/0005/7", bus.o_valid, bus.o_data_a, bus.o_data_b, bus.o_ctrl); end
  endtask

  task automatic test_reset_mid();
    drive_issue(ALU_DIV, 4'd4, 4'd1, 1'b0, 16'h0, 4'd3, 1'b1);
    step();
    drive_idle();
    bus.i_ready = 1'b0;
    n_checks++; if (bus.o_valid !== 1'b1 || bus.o_data_a !== 16'h1234 || bus.o_data_b !== 16'd5 || bus.o_ctrl !== 4'd3)
      begin n_fail++; $display("[TB] FAIL rstmid_pre: got v=%0b a=%h b=%h ctrl=%0d expected 1/1234/0005/3", bus.o_valid, bus.o_data_a, bus.o_data_b, bus.o_ctrl); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (bus.o_valid !== 1'b0 || bus.o_data_a !== 16'h0 || bus.o_data_b !== 16'h0 || bus.o_ctrl !== 4'd0 || bus.o_rd !== 4'd0 || bus.o_rd_we !== 1'b0)
      begin n_fail++; $display("[TB] FAIL rstmid_outputs: got v=%0b a=%h b=%h ctrl=%0d rd=%0d we=%0b expected all 0", bus.o_valid, bus.o_data_a, bus.o_data_b, bus.o_ctrl, bus.o_rd, bus.o_rd_we); end
    bus.i_ready = 1'b1;
    drive_issue(ALU_SHR, 4'd3, 4'd4, 1'b0, 16'h0, 4'd3, 1'b1);
    @(negedge clk);
    n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_pend_clear: got %0b expected 1", bus.o_ready); end
    step();
    drive_idle();
    n_checks++; if (bus.o_valid !== 1'b1 || bus.o_data_a !== 16'h0 || bus.o_data_b !== 16'h0 || bus.o_ctrl !== 4'd8)
      begin n_fail++; $display("[TB] FAIL rstmid_regs_clear: got v=%0b a=%h b=%h ctrl=%0d expected 1/0000/0000/8", bus.o_valid, bus.o_data_a, bus.o_data_b, bus.o_ctrl); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive_idle();
    drive_wb(1'b0, 4'd0, 16'd0);
    bus.i_ready = 1'b1;
    $display("[TB] starting z16_operand_stage directed tests");
    test_reset();
    test_basic();
    test_raw();
    test_backpressure();
    test_imm();
    test_set_wins();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
